// File: rtl/poke_fade_pkg.sv
// rtl/poke_fade_pkg.sv - shared state type, level range and pixel field positions for the screen fader
package poke_fade_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    HOLD,
    FADE_IN
  } fade_state_t;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;

  localparam int R_MSB = 11;
  localparam int G_MSB = 7;
  localparam int B_MSB = 3;

endpackage

// File: rtl/fade_channel_scale.sv
// rtl/fade_channel_scale.sv - scales one 4-bit colour channel by a 0..16 level (FADE_WHITE_EN selects fade to white)
module fade_channel_scale
  import poke_fade_pkg::*;
(
  input  logic [3:0]         chan_in,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [3:0]         chan_out
);

`ifdef FADE_WHITE_EN
  // Distance to white, scaled by how far the level has dropped from full brightness.
  // Largest product is 15*16=240, so 8 bits hold it without loss.
  logic [3:0]         headroom;
  logic [LEVEL_W-1:0] depth;
  logic [7:0]         product;

  assign headroom = 4'hF - chan_in;
  assign depth    = LEVEL_W'(LEVEL_MAX) - level_in;
  assign product  = {4'b0, headroom} * {3'b0, depth};
  // product[7:4] never exceeds headroom, so the sum cannot wrap past 4'hF.
  assign chan_out = chan_in + product[7:4];
`else
  // Plain brightness scale; level 16 returns the channel exactly, level 0 returns 0.
  logic [7:0] product;

  assign product  = {4'b0, chan_in} * {3'b0, level_in};
  assign chan_out = product[7:4];
`endif

endmodule

// File: rtl/screen_fader.sv
// rtl/screen_fader.sv - frame-synchronous fade-out/hold/fade-in pixel stage; define FADE_WHITE_EN to fade to white
module screen_fader
  import poke_fade_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 8
) (
  input  logic        vclk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] pixel_in,
  input  logic        fade_req_in,
  output logic        fade_busy_out,
  output logic        fade_mid_out,
  output logic        fade_done_out,
  output logic        phsync_out,
  output logic        pvsync_out,
  output logic        pblank_out,
  output logic [11:0] pixel_out
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

  fade_state_t        state;
  logic [LEVEL_W-1:0] level;
  logic [CNT_W-1:0]   step_cnt;
  logic               frame_tick;

  logic [11:0]        pixel_s1;
  logic               hsync_s1;
  logic               vsync_s1;
  logic               blank_s1;
  logic [LEVEL_W-1:0] level_s1;
  logic [11:0]        scaled;

  // Top-left pixel marks the frame boundary; level only moves here so a frame never shows two levels.
  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Fade sequencer: counts frame ticks per step, walks the level down, holds at black, walks it back up.
  always_ff @(posedge vclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      level         <= LVL_FULL;
      step_cnt      <= '0;
      fade_busy_out <= 1'b0;
      fade_mid_out  <= 1'b0;
      fade_done_out <= 1'b0;
    end else begin
      fade_mid_out  <= 1'b0;
      fade_done_out <= 1'b0;
      case (state)
        IDLE: begin
          level <= LVL_FULL;
          // A tick arriving with the request is not counted; stepping starts on later ticks.
          if (fade_req_in) begin
            state         <= FADE_OUT;
            step_cnt      <= '0;
            fade_busy_out <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (level != '0) level <= level - LVL_ONE;
              if (level <= LVL_ONE) begin
                state        <= HOLD;
                fade_mid_out <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (step_cnt == HOLD_LAST) begin
              step_cnt <= '0;
              state    <= FADE_IN;
            end else begin
              step_cnt <= step_cnt + CNT_W'(1);
            end
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (level != LVL_FULL) level <= level + LVL_ONE;
              if (level >= LVL_FULL - LVL_ONE) begin
                state         <= IDLE;
                fade_done_out <= 1'b1;
                fade_busy_out <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          level         <= LVL_FULL;
          step_cnt      <= '0;
          fade_busy_out <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the upstream pixel, timing signals and the level in force for this pixel.
  always_ff @(posedge vclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_s1 <= '0;
      hsync_s1 <= 1'b1;
      vsync_s1 <= 1'b1;
      blank_s1 <= 1'b0;
      level_s1 <= LVL_FULL;
    end else begin
      pixel_s1 <= pixel_in;
      hsync_s1 <= hsync_in;
      vsync_s1 <= vsync_in;
      blank_s1 <= blank_in;
      level_s1 <= level;
    end
  end

  fade_channel_scale u_scale_r (
    .chan_in  (pixel_s1[R_MSB -: 4]),
    .level_in (level_s1),
    .chan_out (scaled[R_MSB -: 4])
  );

  fade_channel_scale u_scale_g (
    .chan_in  (pixel_s1[G_MSB -: 4]),
    .level_in (level_s1),
    .chan_out (scaled[G_MSB -: 4])
  );

  fade_channel_scale u_scale_b (
    .chan_in  (pixel_s1[B_MSB -: 4]),
    .level_in (level_s1),
    .chan_out (scaled[B_MSB -: 4])
  );

  // Stage 2: register the scaled pixel (forced black in blanking) alongside the matching syncs.
  always_ff @(posedge vclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out  <= '0;
      phsync_out <= 1'b1;
      pvsync_out <= 1'b1;
      pblank_out <= 1'b0;
    end else begin
      pixel_out  <= blank_s1 ? 12'h000 : scaled;
      phsync_out <= hsync_s1;
      pvsync_out <= vsync_s1;
      pblank_out <= blank_s1;
    end
  end

endmodule

// File: tb/tb_screen_fader.sv
// tb/tb_screen_fader.sv - randomized pixel stream against a tick-count reference model of the fader
module tb_screen_fader;

  localparam int F  = 2;
  localparam int H  = 8;
  localparam int HT = 8;
  localparam int VT = 4;
  localparam int MID_TICK  = 16 * F;
  localparam int DONE_TICK = 32 * F + H;

  logic        vclk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic [11:0] pixel_in;
  logic        fade_req_in;
  logic        fade_busy_out;
  logic        fade_mid_out;
  logic        fade_done_out;
  logic        phsync_out;
  logic        pvsync_out;
  logic        pblank_out;
  logic [11:0] pixel_out;

  always #5 vclk_in = ~vclk_in;

  screen_fader #(.FRAMES_PER_STEP(F), .HOLD_FRAMES(H)) dut (
    .vclk_in       (vclk_in),
    .rst_n_in      (rst_n_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .blank_in      (blank_in),
    .pixel_in      (pixel_in),
    .fade_req_in   (fade_req_in),
    .fade_busy_out (fade_busy_out),
    .fade_mid_out  (fade_mid_out),
    .fade_done_out (fade_done_out),
    .phsync_out    (phsync_out),
    .pvsync_out    (pvsync_out),
    .pblank_out    (pblank_out),
    .pixel_out     (pixel_out)
  );

  typedef struct packed {
    logic [11:0] pix;
    logic        hs;
    logic        vs;
    logic        bl;
  } out_t;

  int   errors = 0;
  int   checks = 0;
  bit   active = 0;
  int   ticks  = 0;
  int   hc = 0;
  int   vc = 0;
  int   mid_seen  = 0;
  int   done_seen = 0;
  out_t pend;
  out_t exp_o;
  logic exp_mid;
  logic exp_done;

  // Brightness implied by how many frame ticks have passed since the request.
  function automatic int model_level();
    if (!active)                return 16;
    if (ticks <= MID_TICK)      return 16 - ticks / F;
    if (ticks <= MID_TICK + H)  return 0;
    return (ticks - MID_TICK - H) / F;
  endfunction

  function automatic int scale(int c, int lvl);
`ifdef FADE_WHITE_EN
    return c + ((15 - c) * (16 - lvl)) / 16;
`else
    return (c * lvl) / 16;
`endif
  endfunction

  function automatic logic [11:0] fade_pix(logic [11:0] p, int lvl, logic bl);
    logic [11:0] r;
    r = '0;
    if (!bl) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = int'(p[k*4 +: 4]);
        r[k*4 +: 4] = 4'(scale(c, lvl));
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One pixel clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic rc(input logic req, input logic [11:0] pix, input logic bl);
    logic tick;
    int   lvl;
    hcount_in   = 11'(hc);
    vcount_in   = 10'(vc);
    pixel_in    = pix;
    blank_in    = bl;
    hsync_in    = 1'($urandom_range(1));
    vsync_in    = 1'($urandom_range(1));
    fade_req_in = req;
    tick = (hc == 0) && (vc == 0);
    @(posedge vclk_in);
    lvl   = model_level();
    exp_o = pend;
    pend  = '{fade_pix(pix, lvl, bl), hsync_in, vsync_in, bl};
    exp_mid  = 1'b0;
    exp_done = 1'b0;
    if (active) begin
      if (tick) begin
        ticks++;
        if (ticks == MID_TICK) exp_mid = 1'b1;
        if (ticks == DONE_TICK) begin
          exp_done = 1'b1;
          active   = 0;
        end
      end
    end else if (req) begin
      active = 1;
      ticks  = 0;
    end
    hc = hc + 1;
    if (hc == HT) begin
      hc = 0;
      vc = (vc + 1) % VT;
    end
    #1;
    chk("pixel", pixel_out, exp_o.pix);
    chk("hsync", phsync_out, exp_o.hs);
    chk("vsync", pvsync_out, exp_o.vs);
    chk("blank", pblank_out, exp_o.bl);
    chk("busy", fade_busy_out, active);
    chk("mid", fade_mid_out, exp_mid);
    chk("done", fade_done_out, exp_done);
    if (fade_mid_out === 1'b1) mid_seen++;
    if (fade_done_out === 1'b1) done_seen++;
    fade_req_in = 1'b0;
  endtask

  task automatic rnd();
    rc(1'b0, 12'($urandom), 1'($urandom_range(3) == 0));
  endtask

  initial begin
    rst_n_in    = 1'b0;
    hcount_in   = '0;
    vcount_in   = '0;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    blank_in    = 1'b0;
    pixel_in    = '0;
    fade_req_in = 1'b0;
    repeat (2) @(posedge vclk_in);
    #1;
    chk("rst_pixel", pixel_out, 12'h000);
    chk("rst_hsync", phsync_out, 1'b1);
    chk("rst_vsync", pvsync_out, 1'b1);
    chk("rst_blank", pblank_out, 1'b0);
    chk("rst_busy", fade_busy_out, 1'b0);
    chk("rst_mid", fade_mid_out, 1'b0);
    chk("rst_done", fade_done_out, 1'b0);
    pend = '{12'h000, 1'b1, 1'b1, 1'b0};
    #2 rst_n_in = 1'b1;

    // Idle pass-through.
    repeat (20) rnd();
    rc(1'b0, 12'hA5F, 1'b0);
    rnd();
    chk("passthru", pixel_out, 12'hA5F);

    // First sequence.
    rc(1'b1, 12'($urandom), 1'b0);
    chk("busy_rise", fade_busy_out, 1'b1);
    while (ticks < 2) rnd();
    rc(1'b0, 12'hFFF, 1'b0);
    rnd();
`ifdef FADE_WHITE_EN
    chk("lvl15_fff", pixel_out, 12'hFFF);
`else
    chk("lvl15_fff", pixel_out, 12'hEEE);
`endif
    while (ticks < MID_TICK + 2) rnd();
    rc(1'b1, 12'($urandom), 1'b0);
    rc(1'b0, 12'h123, 1'b0);
    rc(1'b0, 12'h123, 1'b1);
`ifdef FADE_WHITE_EN
    chk("hold_pix", pixel_out, 12'hFFF);
`else
    chk("hold_pix", pixel_out, 12'h000);
`endif
    rnd();
    chk("hold_blank", pixel_out, 12'h000);
    chk("hold_busy", fade_busy_out, 1'b1);
    while (!(active && ticks == DONE_TICK - 1 && hc == 0 && vc == 0)) rnd();
    rc(1'b1, 12'($urandom), 1'b0);
    chk("done_pulse", fade_done_out, 1'b1);
    repeat (5) rnd();
    chk("req_on_done_ignored", fade_busy_out, 1'b0);
    chk("mid_once", mid_seen, 1);
    chk("done_once", done_seen, 1);

    // Second sequence, abandoned by an off-edge reset during fade-in.
    repeat (7) rnd();
    rc(1'b1, 12'($urandom), 1'b0);
    while (ticks < MID_TICK + H + 5) rnd();
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_pixel", pixel_out, 12'h000);
    chk("arst_hsync", phsync_out, 1'b1);
    chk("arst_vsync", pvsync_out, 1'b1);
    chk("arst_blank", pblank_out, 1'b0);
    chk("arst_busy", fade_busy_out, 1'b0);
    active = 0;
    ticks  = 0;
    pend   = '{12'h000, 1'b1, 1'b1, 1'b0};
    @(posedge vclk_in);
    #1;
    chk("arst_hold_busy", fade_busy_out, 1'b0);
    chk("arst_hold_done", fade_done_out, 1'b0);
    #2 rst_n_in = 1'b1;
    rc(1'b0, 12'h3C7, 1'b0);
    rnd();
    chk("post_rst_pass", pixel_out, 12'h3C7);
    repeat (10) rnd();

    // Third sequence, requested on a frame tick, run to completion.
    while (!(hc == 0 && vc == 0)) rnd();
    rc(1'b1, 12'($urandom), 1'b0);
    while (active) rnd();
    repeat (5) rnd();
    chk("mid_total", mid_seen, 3);
    chk("done_total", done_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_fader.md
Name: screen_fader

Overview:
- Final pixel stage between the game pixel mux and the XVGA output pins.
- Consumes the mux's pixel, hsync, vsync and blank; produces a faded copy, delay-matched so all outputs stay aligned.
- Runs a frame-synchronous fade-out / hold / fade-in sequence on request.
- fade_mid_out marks full black, the point where the game swaps scenes (overworld to battle and back) without a visible tear.

Parameters:
- FRAMES_PER_STEP, 2: frame ticks per brightness step.
- HOLD_FRAMES, 8: frame ticks held at level 0.

Ports:
- vclk_in  input  1  65 MHz pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- hsync_in  input  1  upstream horizontal sync (active low)
- vsync_in  input  1  upstream vertical sync (active low)
- blank_in  input  1  upstream blanking (1 = black)
- pixel_in  input  12  upstream pixel; r=11:8, g=7:4, b=3:0
- fade_req_in  input  1  one-cycle request to start a sequence
- fade_busy_out  output  1  high while a sequence is running
- fade_mid_out  output  1  one-cycle pulse on reaching full black
- fade_done_out  output  1  one-cycle pulse on sequence completion
- phsync_out  output  1  hsync delayed 2 cycles
- pvsync_out  output  1  vsync delayed 2 cycles
- pblank_out  output  1  blank delayed 2 cycles
- pixel_out  output  12  faded pixel

Behaviour:
- Reset (async, rst_n_in=0):
  - state IDLE, level=16, counters 0.
  - All outputs 0, except phsync_out=1 and pvsync_out=1.
  - Reset may assert at any time, mid-sequence included; the sequence is abandoned with no mid/done pulse.
- Frame tick: hcount_in==0 && vcount_in==0. Level changes only on a frame tick, so level is constant across a visible frame.
- Level is 5 bits, range 0..16.
- Pixel datapath, 2-stage pipeline (latency 2):
  - Stage 1 registers pixel, syncs, blank and the current level.
  - Stage 2 computes each channel as (c*level)>>4 (4x5-bit product, 9-bit intermediate, take bits 7:4). level=16 yields c exactly; level=0 yields 0.
  - If the delayed blank is 1, pixel_out=0.
  - The syncs carry the same 2-cycle delay as the pixel.
- State machine:
  - IDLE: level=16, busy=0. fade_req_in=1 moves to FADE_OUT next cycle and asserts busy.
  - FADE_OUT: count frame ticks; on every FRAMES_PER_STEP-th tick, level decrements by 1. When level reaches 0, go to HOLD and pulse fade_mid_out in that same cycle.
  - HOLD: after HOLD_FRAMES frame ticks, go to FADE_IN.
  - FADE_IN: on every FRAMES_PER_STEP-th tick, level increments by 1. When level reaches 16, go to IDLE, pulse fade_done_out, and drop busy in the same cycle.
- Default total sequence: 32+8+32 = 72 frame ticks.
- The step counter clears on every state change.
- fade_req_in while busy is ignored, including the cycle done pulses (the state is still FADE_IN then).
- fade_req_in coincident with a frame tick in IDLE: enter FADE_OUT; the first decrement is counted from the following ticks.
- Level saturates at 0 and 16 and never wraps.

Optional Feature:
- FADE_WHITE_EN defined: each channel fades toward white, computed as c + (((15-c)*(16-level))>>4). level=0 gives 4'hF, level=16 gives c. Blank still forces 0.
- FADE_WHITE_EN undefined: fade to black as specified above.
- The state machine and timing are identical in both builds.

Decomposition:
- Package poke_fade_pkg holds:
  - the fade_state_t enum {IDLE, FADE_OUT, HOLD, FADE_IN};
  - LEVEL_MAX=16 and LEVEL_W=5;
  - pixel field constants R_MSB, G_MSB, B_MSB.
- Sub-module fade_channel_scale: one 4-bit channel times a 5-bit level, implementing both the black and white variants. Instantiated three times in stage 2.

Test Plan:
- Reset then idle: pixel_in=12'hA5F, blank_in=0 -> pixel_out=12'hA5F exactly 2 cycles later; syncs are delayed 2 cycles.
- Pulse fade_req_in with defaults -> busy rises the next cycle; level is 15 after 2 frame ticks; pixel_in=12'hFFF gives 12'hEEE.
- Continue the sequence -> fade_mid_out pulses once at tick 32, pixel_out=0 during HOLD; fade_done_out pulses once at tick 72; busy falls with done.
- Pulse fade_req_in during HOLD and again on the cycle done pulses -> both ignored; no second sequence starts.
- Assert rst_n_in=0 mid FADE_IN, asynchronously off-edge -> outputs clear immediately; after release, level=16 and pixel passes through unchanged.
- FADE_WHITE_EN build, at HOLD with pixel_in=12'h123 -> pixel_out=12'hFFF; with blank_in=1 -> pixel_out=0.
